// File: rtl/led_fade_driver_if.sv
// led_fade_driver_if: groups the LED fader's level input, bypass control and
// status/readback outputs so the blinker side and the fader share one bundle.
// The master side drives the target level and bypass. The slave side is the
// fader, which returns the pad drive and its status.
interface led_fade_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                led_in;
    logic                bypass;
    logic                led_out;
    logic [PWM_BITS-1:0] level;
    logic                busy;
    logic [1:0]          state;

    modport master (
        output led_in,
        output bypass,
        input  led_out,
        input  level,
        input  busy,
        input  state
    );

    modport slave (
        input  led_in,
        input  bypass,
        output led_out,
        output level,
        output busy,
        output state
    );
endinterface

// File: rtl/led_fade_driver.sv
// led_fade_driver: turns the blinker's on/off LED level into a linear PWM
// fade-in / fade-out on the LED pad, with status outputs for debug and CPU
// readback. It runs in the same clock domain as the blinker, so led_in needs
// no synchroniser.
//
// Build option: define LED_FADE_GAMMA_EN to use a square-law duty curve,
// duty = (level*level) >> PWM_BITS. The product is registered once, and all
// other inputs to the pad-drive decision are delayed to match it. This gives
// led_out a 2-cycle latency in every state. Without the macro, duty = level
// and led_out has a 1-cycle latency.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  OFF        | LED dark, level held at 0, step timer idle
//  FADE_UP    | level rises by one every STEP_DIV cycles toward MAX
//  ON         | LED solid on, level held at MAX, step timer idle
//  FADE_DOWN  | level falls by one every STEP_DIV cycles toward 0
module led_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input  logic              clk,
    input  logic              rst,
    led_fade_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_FADE_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_FADE_DOWN = 2'd3
    } state_t;

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] LVL_NEAR  = LVL_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

    state_t              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                led_out_q;
    logic                step_tick;

    assign step_tick = (step_cnt_q == STEP_LAST);

    // Pad-drive decision. Bypass passes led_in straight through. ON is forced
    // solid rather than MAX/(MAX+1) duty. A fading state compares the PWM
    // counter against the duty.
    function automatic logic pwm_drive(
        input state_t              st,
        input logic [PWM_BITS-1:0] pwm,
        input logic [PWM_BITS-1:0] dty,
        input logic                byp,
        input logic                li
    );
        logic d;
        d = 1'b0;
        if (byp) begin
            d = li;
        end else begin
            case (st)
                ST_OFF:  d = 1'b0;
                ST_ON:   d = 1'b1;
                default: d = (pwm < dty);
            endcase
        end
        return d;
    endfunction

    // Free-running PWM counter; wraps MAX -> 0 naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // Fade FSM with its step timer and brightness level. A direction change
    // takes precedence over a coincident step tick. Completion is tested with
    // >= MAX-1 (and <= 1) rather than equality. A fade that starts already at
    // its end level, for example a reversal straight out of ON or OFF,
    // therefore still terminates on its first tick instead of saturating
    // forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            level_q    <= '0;
            step_cnt_q <= '0;
        end else if (bus.bypass) begin
            state_q    <= bus.led_in ? ST_ON : ST_OFF;
            level_q    <= bus.led_in ? LVL_MAX : '0;
            step_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    level_q    <= '0;
                    step_cnt_q <= '0;
                    if (bus.led_in) begin
                        state_q <= ST_FADE_UP;
                    end
                end
                ST_FADE_UP: begin
                    if (!bus.led_in) begin
                        state_q    <= ST_FADE_DOWN;
                        step_cnt_q <= '0;
                    end else if (step_tick) begin
                        step_cnt_q <= '0;
                        if (level_q >= LVL_NEAR) begin
                            level_q <= LVL_MAX;
                            state_q <= ST_ON;
                        end else begin
                            level_q <= level_q + 1'b1;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    level_q    <= LVL_MAX;
                    step_cnt_q <= '0;
                    if (!bus.led_in) begin
                        state_q <= ST_FADE_DOWN;
                    end
                end
                ST_FADE_DOWN: begin
                    if (bus.led_in) begin
                        state_q    <= ST_FADE_UP;
                        step_cnt_q <= '0;
                    end else if (step_tick) begin
                        step_cnt_q <= '0;
                        if (level_q <= LVL_ONE) begin
                            level_q <= '0;
                            state_q <= ST_OFF;
                        end else begin
                            level_q <= level_q - 1'b1;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_OFF;
                    level_q    <= '0;
                    step_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_ext;
    logic [PWM_BITS-1:0]   duty_gamma;
    logic [PWM_BITS-1:0]   duty_d_q;
    logic [PWM_BITS-1:0]   pwm_d_q;
    state_t                state_d_q;
    logic                  byp_d_q;
    logic                  li_d_q;

    assign level_ext  = {{PWM_BITS{1'b0}}, level_q};
    assign duty_gamma = PWM_BITS'((level_ext * level_ext) >> PWM_BITS);

    // Multiply stage: register the squared duty along with the state, PWM
    // phase and bypass inputs it must be compared against.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_d_q  <= '0;
            pwm_d_q   <= '0;
            state_d_q <= ST_OFF;
            byp_d_q   <= 1'b0;
            li_d_q    <= 1'b0;
        end else begin
            duty_d_q  <= duty_gamma;
            pwm_d_q   <= pwm_cnt_q;
            state_d_q <= state_q;
            byp_d_q   <= bus.bypass;
            li_d_q    <= bus.led_in;
        end
    end

    // Registered pad drive from the delayed snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out_q <= 1'b0;
        end else begin
            led_out_q <= pwm_drive(state_d_q, pwm_d_q, duty_d_q, byp_d_q, li_d_q);
        end
    end
`else
    // Registered pad drive from this cycle's state, level and PWM phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out_q <= 1'b0;
        end else begin
            led_out_q <= pwm_drive(state_q, pwm_cnt_q, level_q, bus.bypass, bus.led_in);
        end
    end
`endif

    assign bus.led_out = led_out_q;
    assign bus.level   = level_q;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q == ST_FADE_UP) || (state_q == ST_FADE_DOWN);

endmodule
